// File: rtl/uart_tx_fifo_if.sv
// Producer/line interface of uart_tx_fifo.
//   data_tx    : word to transmit (producer -> transmitter)
//   valid_in   : data_tx valid (producer -> transmitter)
//   ready_out  : FIFO can accept a word (transmitter -> producer)
//   uart_out   : serial TX line, idle high
//   busy       : frame on the line
//   tx_done    : one-cycle pulse at the end of each frame
//   fifo_count : words currently buffered
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
  parameter int unsigned BITS_N     = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH + 1);

  logic [BITS_N-1:0] data_tx;
  logic              valid_in;
  logic              ready_out;
  logic              uart_out;
  logic              busy;
  logic              tx_done;
  logic [CountW-1:0] fifo_count;

  modport master (
    output data_tx, valid_in,
    input  ready_out, uart_out, busy, tx_done, fifo_count
  );

  modport slave (
    input  data_tx, valid_in,
    output ready_out, uart_out, busy, tx_done, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with an input FIFO.
// Words pushed through the valid/ready handshake are buffered and sent as
// START, BITS_N data bits (LSB first), optional parity, STOP_BITS stop bits.
// Frames run back to back while the FIFO holds words.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : uart_tx_fifo_if.slave (data_tx, valid_in, ready_out, uart_out, busy,
//         tx_done, fifo_count)
module uart_tx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BITS_N       = 8,
  parameter int unsigned PARITY_TYPE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned StopClks = STOP_BITS * CLKS_PER_BIT;
  localparam int unsigned BaudW    = $clog2(StopClks);
  localparam int unsigned IdxW     = $clog2(BITS_N);
  // PARITY_TYPE 3 falls through to "no parity".
  localparam bit          HasParity = (PARITY_TYPE == 1) || (PARITY_TYPE == 2);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (BITS_N < 5 || BITS_N > 9) begin : g_bad_bits_n
    $error("uart_tx_fifo: BITS_N must be in 5..9");
  end
  if (PARITY_TYPE > 3) begin : g_bad_parity_type
    $error("uart_tx_fifo: PARITY_TYPE must be 0..3");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [BITS_N-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              ready;
  logic              push, pop, empty;
  logic [BITS_N-1:0] head;

  assign ready = (count_q < CountW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.valid_in && ready;
  assign head  = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.data_tx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [BaudW-1:0]  baud_q, baud_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              line_q, line_d;
  logic              start_frame, done;
  logic              bit_end, stop_end;

  assign bit_end  = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign stop_end = (baud_q == BaudW'(StopClks - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    line_d      = line_q;
    start_frame = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        baud_d      = '0;
        line_d      = 1'b1;
        start_frame = !empty;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          baud_d  = '0;
          line_d  = shift_q[0];
        end
      end
      StData: begin
        if (bit_end) begin
          baud_d = '0;
          if (idx_q == IdxW'(BITS_N - 1)) begin
            if (HasParity) begin
              state_d = StParity;
              line_d  = par_q;
            end else begin
              state_d = StStop;
              line_d  = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          baud_d  = '0;
          line_d  = 1'b1;
        end
      end
      StStop: begin
        if (stop_end) begin
          done   = 1'b1;
          baud_d = '0;
          if (empty) begin
            state_d = StIdle;
            line_d  = 1'b1;
          end else begin
            // Chain straight into the next start bit, no idle cycle.
            start_frame = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        baud_d  = '0;
        line_d  = 1'b1;
      end
    endcase

    // Pop the head into the shifter; parity is fixed from the unshifted word.
    if (start_frame) begin
      state_d = StStart;
      baud_d  = '0;
      idx_d   = '0;
      shift_d = head;
      par_d   = (PARITY_TYPE == 1) ? ~^head : ^head;
      line_d  = 1'b0;
    end
  end

  assign pop = start_frame;

  assign bus.ready_out  = ready;
  assign bus.fifo_count = count_q;
  assign bus.uart_out   = line_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.tx_done    = done;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Four transmitter configurations share one stimulus stream:
//   cfg0: 8 bits, no parity, 1 stop   cfg1: 8 bits, even, 1 stop
//   cfg2: 8 bits, odd, 1 stop         cfg3: 7 bits, even, 2 stop
// Each has a queue/timeline model checked every cycle, plus literal checks.
module tb_uart_tx_fifo;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] data_tx = '0;
  logic       valid_in = 1'b0;
  logic [3:0] en = 4'hF;

  logic [3:0] line_w, busy_w, done_w, ready_w;
  logic [2:0] count_w [4];

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] s_line [100];
  logic [3:0] s_busy [100];
  logic [3:0] s_done [100];

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int BN  = (g == 3) ? 7 : 8;
    localparam int PT  = (g == 1 || g == 3) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SB  = (g == 3) ? 2 : 1;
    localparam int FL  = 1 + BN + ((PT != 0) ? 1 : 0) + SB;
    localparam int LEN = FL * CPB;

    uart_tx_fifo_if #(.BITS_N(BN), .FIFO_DEPTH(DEPTH)) bus ();

    assign bus.data_tx  = data_tx[BN-1:0];
    assign bus.valid_in = valid_in & en[g];
    assign line_w[g]    = bus.uart_out;
    assign busy_w[g]    = bus.busy;
    assign done_w[g]    = bus.tx_done;
    assign ready_w[g]   = bus.ready_out;
    assign count_w[g]   = bus.fifo_count;

    uart_tx_fifo #(
      .CLKS_PER_BIT(CPB),
      .BITS_N      (BN),
      .PARITY_TYPE (PT),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    // Model: FIFO as a queue, current frame as a bit list plus cycle index.
    logic [8:0]  mq [$];
    bit          m_act = 1'b0;
    int          m_t = 0;
    logic [15:0] m_frame = '1;
    bit          m_push;
    logic [8:0]  m_pd;

    function automatic logic [15:0] build(input logic [8:0] d);
      logic [15:0] f;
      int ones;
      f = '1;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < BN; i++) begin
        f[1+i] = d[i];
        ones += int'(d[i]);
      end
      if (PT == 1) f[1+BN] = ((ones % 2) == 0);
      if (PT == 2) f[1+BN] = ((ones % 2) == 1);
      return f;
    endfunction

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mq.delete();
        m_act = 1'b0;
        m_t = 0;
      end else begin
        m_push = valid_in && en[g] && (mq.size() < DEPTH);
        m_pd = data_tx;
        if (m_act && m_t != LEN - 1) begin
          m_t++;
        end else if (mq.size() > 0) begin
          m_frame = build(mq.pop_front());
          m_act = 1'b1;
          m_t = 0;
        end else begin
          m_act = 1'b0;
        end
        if (m_push) mq.push_back(m_pd);
      end
    end

    always @(negedge clk) begin
      chk($sformatf("cfg%0d uart_out", g), int'(bus.uart_out),
          m_act ? int'(m_frame[m_t / CPB]) : 1);
      chk($sformatf("cfg%0d busy", g), int'(bus.busy), int'(m_act));
      chk($sformatf("cfg%0d tx_done", g), int'(bus.tx_done),
          (m_act && m_t == LEN - 1) ? 1 : 0);
      chk($sformatf("cfg%0d fifo_count", g), int'(bus.fifo_count), mq.size());
      chk($sformatf("cfg%0d ready_out", g), int'(bus.ready_out),
          (mq.size() < DEPTH) ? 1 : 0);
    end
  end

  task automatic step_sample(input int c);
    @(negedge clk);
    s_line[c] = line_w;
    s_busy[c] = busy_w;
    s_done[c] = done_w;
  endtask

  task automatic push_and_capture(input logic [8:0] d, input int n);
    data_tx = d;
    valid_in = 1'b1;
    step_sample(0);
    valid_in = 1'b0;
    for (int c = 1; c < n; c++) step_sample(c);
  endtask

  function automatic int busy_cycles(input int g, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) k += int'(s_busy[c][g]);
    return k;
  endfunction

  function automatic int done_pulses(input int g, input int n);
    int k = 0;
    for (int c = 0; c < n; c++) k += int'(s_done[c][g]);
    return k;
  endfunction

  initial begin
    logic [9:0]  e1;
    logic [10:0] e5;
    logic [8:0]  words [6];
    int i, guard, t, dones;
    logic r;

    e1 = 10'b1101001010;   // 0xA5: start, 1,0,1,0,0,1,0,1, stop
    e5 = 11'b11010000010;  // 0x41, 7 bits, even parity 0, two stops
    words[0] = 9'h011; words[1] = 9'h022; words[2] = 9'h033;
    words[3] = 9'h044; words[4] = 9'h055; words[5] = 9'h066;

    // Reset state
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset cfg%0d uart_out", g), int'(line_w[g]), 1);
      chk($sformatf("reset cfg%0d busy", g), int'(busy_w[g]), 0);
      chk($sformatf("reset cfg%0d tx_done", g), int'(done_w[g]), 0);
      chk($sformatf("reset cfg%0d fifo_count", g), int'(count_w[g]), 0);
      chk($sformatf("reset cfg%0d ready_out", g), int'(ready_w[g]), 1);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame 0xA5
    push_and_capture(9'h0A5, 60);
    chk("t1 line high on accept cycle", int'(s_line[0][0]), 1);
    chk("t1 start bit next cycle", int'(s_line[1][0]), 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1 bit%0d", k), int'(s_line[3 + 4 * k][0]), int'(e1[k]));
    end
    chk("t1 frame length", busy_cycles(0, 60), 40);
    chk("t1 tx_done at cycle 40", int'(s_done[40][0]), 1);
    chk("t1 tx_done count", done_pulses(0, 60), 1);
    chk("t1 busy falls after done", int'(s_busy[41][0]), 0);

    // Parity with 0x07
    push_and_capture(9'h007, 60);
    chk("t2 even parity bit", int'(s_line[39][1]), 1);
    chk("t2 odd parity bit", int'(s_line[39][2]), 0);
    chk("t2 even frame length", busy_cycles(1, 60), 44);
    chk("t2 odd frame length", busy_cycles(2, 60), 44);

    // 7 bits, even parity, 2 stops with 0x41
    push_and_capture(9'h041, 60);
    for (int k = 0; k < 11; k++) begin
      chk($sformatf("t5 bit%0d", k), int'(s_line[3 + 4 * k][3]), int'(e5[k]));
    end
    chk("t5 frame length", busy_cycles(3, 60), 44);

    // Burst of 6 words into cfg0 with valid held high
    en = 4'b0001;
    i = 0;
    guard = 0;
    dones = 0;
    while (i < 6 && guard < 500) begin
      data_tx = words[i];
      valid_in = 1'b1;
      r = ready_w[0];
      @(negedge clk);
      guard++;
      dones += int'(done_w[0]);
      if (r) i++;
      if (guard == 5) begin
        chk("t3 fifo_count full", int'(count_w[0]), 4);
        chk("t3 ready_out low when full", int'(ready_w[0]), 0);
      end
    end
    valid_in = 1'b0;
    chk("t3 sixth word accept cycle", guard, 43);
    t = 0;
    while (!(busy_w[0] == 1'b0 && count_w[0] == 3'd0) && t < 400) begin
      @(negedge clk);
      t++;
      dones += int'(done_w[0]);
    end
    chk("t3 drained in time", (t < 400) ? 1 : 0, 1);
    chk("t3 tx_done count", dones, 6);
    en = 4'hF;
    repeat (2) @(negedge clk);

    // Back to back 0x55, 0xAA
    data_tx = 9'h055;
    valid_in = 1'b1;
    step_sample(0);
    data_tx = 9'h0AA;
    step_sample(1);
    valid_in = 1'b0;
    for (int c = 2; c < 100; c++) step_sample(c);
    chk("t4 first tx_done", int'(s_done[40][0]), 1);
    chk("t4 second start immediate", int'(s_line[41][0]), 0);
    chk("t4 second tx_done", int'(s_done[80][0]), 1);
    chk("t4 tx_done count", done_pulses(0, 100), 2);
    chk("t4 busy continuous", busy_cycles(0, 100), 80);
    chk("t4 busy falls", int'(s_busy[81][0]), 0);

    // Reset during data bit 2 with 2 words queued
    data_tx = 9'h000;
    valid_in = 1'b1;
    step_sample(0);
    data_tx = 9'h00F;
    step_sample(1);
    data_tx = 9'h0F0;
    step_sample(2);
    valid_in = 1'b0;
    for (int c = 3; c <= 14; c++) step_sample(c);
    chk("t6 line low in data bit 2", int'(line_w[0]), 0);
    chk("t6 two words queued", int'(count_w[0]), 2);
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t6 cfg%0d uart_out on rst", g), int'(line_w[g]), 1);
      chk($sformatf("t6 cfg%0d busy on rst", g), int'(busy_w[g]), 0);
      chk($sformatf("t6 cfg%0d fifo_count on rst", g), int'(count_w[g]), 0);
      chk($sformatf("t6 cfg%0d ready_out on rst", g), int'(ready_w[g]), 1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 60; c++) step_sample(c);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("t6 cfg%0d no tx_done after rst", g), done_pulses(g, 60), 0);
    end
    push_and_capture(9'h0A5, 60);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t6 clean bit%0d", k), int'(s_line[3 + 4 * k][0]), int'(e1[k]));
    end
    chk("t6 clean frame length", busy_cycles(0, 60), 40);
    chk("t6 clean tx_done count", done_pulses(0, 60), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
